transaction_ctrl: RTL and testbench

TRANSACTION_CTRL -- requirements
Module: transaction_ctrl

---
 rtl/transaction_ctrl.sv | 107 ++++++++++
 tb/tb_transaction_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/transaction_ctrl.sv
// transaction_ctrl: FIFO transaction FSM with threshold registers, MF pop and round-robin VC pop arbitration
module transaction_ctrl #(
  parameter int MF_SIZE = 2,
  parameter int VC_SIZE = 3,
  parameter int D_SIZE  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [MF_SIZE-1:0] MF_full_umbral_in,
  input  logic [MF_SIZE-1:0] MF_empty_umbral_in,
  input  logic [VC_SIZE-1:0] VC_full_umbral_in,
  input  logic [VC_SIZE-1:0] VC_empty_umbral_in,
  input  logic [D_SIZE-1:0]  D_full_umbral_in,
  input  logic [D_SIZE-1:0]  D_empty_umbral_in,
  input  logic [4:0]         fifo_empty,
  input  logic [4:0]         fifo_error,
  input  logic [3:0]         almost_full,
  input  logic               mf_head_vc,
  input  logic               vc0_head_d,
  input  logic               vc1_head_d,
  output logic [MF_SIZE-1:0] MF_full_umbral_out,
  output logic [MF_SIZE-1:0] MF_empty_umbral_out,
  output logic [VC_SIZE-1:0] VC_full_umbral_out,
  output logic [VC_SIZE-1:0] VC_empty_umbral_out,
  output logic [D_SIZE-1:0]  D_full_umbral_out,
  output logic [D_SIZE-1:0]  D_empty_umbral_out,
  output logic               pop_MF,
  output logic               pop_VC0,
  output logic               pop_VC1,
  output logic [2:0]         state_out,
  output logic               idle_out,
  output logic               active_out,
  output logic               error_out,
  output logic [4:0]         error_src
);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;
  state_t state_q, state_d;
  logic [MF_SIZE-1:0] mf_full_q, mf_full_d, mf_empty_q, mf_empty_d;
  logic [VC_SIZE-1:0] vc_full_q, vc_full_d, vc_empty_q, vc_empty_d;
  logic [D_SIZE-1:0]  d_full_q, d_full_d, d_empty_q, d_empty_d;
  logic [4:0]         error_src_q, error_src_d;
  logic               last_vc_q, last_vc_d;
  logic               run, ld, act, el0, el1;
  always_comb begin
    run = state_q == S_IDLE || state_q == S_ACTIVE;
    ld  = state_q == S_INIT;
    act = state_q == S_ACTIVE;
    state_d = state_q == S_RESET ? S_INIT :
              state_q == S_INIT  ? (init ? S_INIT : S_IDLE) :
              run ? (|fifo_error ? S_ERROR : init ? S_INIT : ~&fifo_empty ? S_ACTIVE : S_IDLE) :
              state_q == S_ERROR ? S_ERROR : S_RESET;
    error_src_d = run && |fifo_error ? fifo_error : error_src_q;
    mf_full_d  = ld ? MF_full_umbral_in  : mf_full_q;
    mf_empty_d = ld ? MF_empty_umbral_in : mf_empty_q;
    vc_full_d  = ld ? VC_full_umbral_in  : vc_full_q;
    vc_empty_d = ld ? VC_empty_umbral_in : vc_empty_q;
    d_full_d   = ld ? D_full_umbral_in   : d_full_q;
    d_empty_d  = ld ? D_empty_umbral_in  : d_empty_q;
    pop_MF  = act & ~fifo_empty[0] & ~almost_full[{1'b0, mf_head_vc}];
    el0     = act & ~fifo_empty[1] & ~almost_full[{1'b1, vc0_head_d}];
    el1     = act & ~fifo_empty[2] & ~almost_full[{1'b1, vc1_head_d}];
    pop_VC0 = el0 & (~el1 | last_vc_q);
    pop_VC1 = el1 & (~el0 | ~last_vc_q);
    last_vc_d = pop_VC0 ? 1'b0 : pop_VC1 ? 1'b1 : last_vc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RESET;
      mf_full_q   <= '0;
      mf_empty_q  <= '0;
      vc_full_q   <= '0;
      vc_empty_q  <= '0;
      d_full_q    <= '0;
      d_empty_q   <= '0;
      error_src_q <= '0;
      last_vc_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      mf_full_q   <= mf_full_d;
      mf_empty_q  <= mf_empty_d;
      vc_full_q   <= vc_full_d;
      vc_empty_q  <= vc_empty_d;
      d_full_q    <= d_full_d;
      d_empty_q   <= d_empty_d;
      error_src_q <= error_src_d;
      last_vc_q   <= last_vc_d;
    end
  end
  assign MF_full_umbral_out  = mf_full_q;
  assign MF_empty_umbral_out = mf_empty_q;
  assign VC_full_umbral_out  = vc_full_q;
  assign VC_empty_umbral_out = vc_empty_q;
  assign D_full_umbral_out   = d_full_q;
  assign D_empty_umbral_out  = d_empty_q;
  assign state_out  = state_q;
  assign idle_out   = state_q == S_IDLE;
  assign active_out = state_q == S_ACTIVE;
  assign error_out  = state_q == S_ERROR;
  assign error_src  = error_src_q;
endmodule

// File: tb/tb_transaction_ctrl.sv
// tb_transaction_ctrl: directed plus randomized checking of transaction_ctrl against a behavioural model
module tb_transaction_ctrl;
  logic       clk = 1'b0;
  logic       reset, init;
  logic [1:0] mf_f_in, mf_e_in, d_f_in, d_e_in;
  logic [2:0] vc_f_in, vc_e_in;
  logic [4:0] fifo_empty, fifo_error;
  logic [3:0] almost_full;
  logic       mf_head_vc, vc0_head_d, vc1_head_d;
  logic [1:0] mf_f_out, mf_e_out, d_f_out, d_e_out;
  logic [2:0] vc_f_out, vc_e_out;
  logic       pop_mf, pop_vc0, pop_vc1, idle_out, active_out, error_out;
  logic [2:0] state_out;
  logic [4:0] error_src;
  int         vectors = 0, errs = 0;
  int         ms = 0;
  logic [1:0] m_mf_f = 0, m_mf_e = 0, m_d_f = 0, m_d_e = 0;
  logic [2:0] m_vc_f = 0, m_vc_e = 0;
  logic [4:0] m_err = 0;
  logic       m_last = 1'b1;

  always #5 clk = ~clk;

  transaction_ctrl dut (
    .clk(clk), .reset(reset), .init(init),
    .MF_full_umbral_in(mf_f_in), .MF_empty_umbral_in(mf_e_in),
    .VC_full_umbral_in(vc_f_in), .VC_empty_umbral_in(vc_e_in),
    .D_full_umbral_in(d_f_in), .D_empty_umbral_in(d_e_in),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error), .almost_full(almost_full),
    .mf_head_vc(mf_head_vc), .vc0_head_d(vc0_head_d), .vc1_head_d(vc1_head_d),
    .MF_full_umbral_out(mf_f_out), .MF_empty_umbral_out(mf_e_out),
    .VC_full_umbral_out(vc_f_out), .VC_empty_umbral_out(vc_e_out),
    .D_full_umbral_out(d_f_out), .D_empty_umbral_out(d_e_out),
    .pop_MF(pop_mf), .pop_VC0(pop_vc0), .pop_VC1(pop_vc1),
    .state_out(state_out), .idle_out(idle_out), .active_out(active_out),
    .error_out(error_out), .error_src(error_src)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    bit act, e_mf, e0, e1, g0, g1;
    int ns;
    @(negedge clk);
    act  = ms == 3;
    e_mf = act && !fifo_empty[0] && !almost_full[mf_head_vc ? 1 : 0];
    e0   = act && !fifo_empty[1] && !almost_full[vc0_head_d ? 3 : 2];
    e1   = act && !fifo_empty[2] && !almost_full[vc1_head_d ? 3 : 2];
    g0   = e0 && (!e1 || m_last == 1'b1);
    g1   = e1 && !g0;
    chk("state", 8'(state_out), 8'(ms));
    chk("idle", 8'(idle_out), 8'(ms == 2));
    chk("active", 8'(active_out), 8'(ms == 3));
    chk("error", 8'(error_out), 8'(ms == 4));
    chk("error_src", 8'(error_src), 8'(m_err));
    chk("mf_full", 8'(mf_f_out), 8'(m_mf_f));
    chk("mf_empty", 8'(mf_e_out), 8'(m_mf_e));
    chk("vc_full", 8'(vc_f_out), 8'(m_vc_f));
    chk("vc_empty", 8'(vc_e_out), 8'(m_vc_e));
    chk("d_full", 8'(d_f_out), 8'(m_d_f));
    chk("d_empty", 8'(d_e_out), 8'(m_d_e));
    chk("pop_mf", 8'(pop_mf), 8'(e_mf));
    chk("pop_vc0", 8'(pop_vc0), 8'(g0));
    chk("pop_vc1", 8'(pop_vc1), 8'(g1));
    @(posedge clk);
    if (reset) begin
      ms = 0; m_err = 0; m_last = 1'b1;
      m_mf_f = 0; m_mf_e = 0; m_vc_f = 0; m_vc_e = 0; m_d_f = 0; m_d_e = 0;
    end else begin
      if (ms == 1) begin
        m_mf_f = mf_f_in; m_mf_e = mf_e_in; m_vc_f = vc_f_in;
        m_vc_e = vc_e_in; m_d_f = d_f_in; m_d_e = d_e_in;
      end
      if (g0) m_last = 1'b0;
      if (g1) m_last = 1'b1;
      if (ms == 0) ns = 1;
      else if (ms == 1) ns = init ? 1 : 2;
      else if (ms == 4) ns = 4;
      else if (fifo_error != 0) begin ns = 4; m_err = fifo_error; end
      else if (init) ns = 1;
      else if (fifo_empty != 5'b11111) ns = 3;
      else ns = 2;
      ms = ns;
    end
    #1;
  endtask

  task automatic thr(input logic [1:0] mf, me, input logic [2:0] vf, ve, input logic [1:0] df, de);
    mf_f_in = mf; mf_e_in = me; vc_f_in = vf; vc_e_in = ve; d_f_in = df; d_e_in = de;
  endtask

  initial begin
    reset = 1; init = 1; thr(2, 1, 5, 2, 2, 1);
    fifo_empty = 5'b11111; fifo_error = 0; almost_full = 0;
    mf_head_vc = 0; vc0_head_d = 0; vc1_head_d = 1;
    @(posedge clk); #1;
    cyc(); cyc();
    reset = 0;
    cyc(); cyc(); cyc();
    chk("req19_mf_full", 8'(mf_f_out), 8'd2);
    chk("req19_vc_full", 8'(vc_f_out), 8'd5);
    init = 0;
    cyc(); cyc();
    chk("req20_idle", 8'(idle_out), 8'd1);
    fifo_empty = 5'b11110;
    cyc(); cyc();
    almost_full = 4'b0001; cyc();
    mf_head_vc = 1; cyc();
    almost_full = 0; fifo_empty = 5'b11000;
    repeat (4) cyc();
    almost_full = 4'b0100;
    repeat (2) cyc();
    almost_full = 0;
    fifo_error = 5'b01000; cyc();
    fifo_error = 0; cyc();
    chk("req22_error_src", 8'(error_src), 8'h08);
    init = 1; repeat (2) cyc();
    reset = 1; cyc();
    reset = 0; thr(1, 3, 7, 4, 3, 2); cyc(); cyc();
    init = 0; fifo_empty = 5'b00000; cyc(); cyc();
    init = 1; thr(3, 2, 6, 1, 1, 3); cyc(); cyc();
    chk("req23_vc_empty", 8'(vc_e_out), 8'd1);
    init = 0; cyc(); cyc();
    init = 1; fifo_error = 5'b00001; cyc();
    init = 0; fifo_error = 0; cyc(); cyc();
    reset = 1; cyc(); reset = 0;
    repeat (600) begin
      reset = $urandom_range(0, 39) == 0;
      init = $urandom_range(0, 7) == 0;
      thr(2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 2'($urandom));
      fifo_empty = 5'($urandom) & 5'($urandom);
      fifo_error = $urandom_range(0, 29) == 0 ? 5'($urandom) : 5'd0;
      almost_full = 4'($urandom) & 4'($urandom);
      mf_head_vc = 1'($urandom); vc0_head_d = 1'($urandom); vc1_head_d = 1'($urandom);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
